// File: rtl/mult_pkg.sv
// Shared definitions for the parallel saturating multiplier.
// Holds the rounding-mode encoding and the fixed pipeline depth.
// Both the lane and the top import this package.
package mult_pkg;

  typedef enum logic [1:0] {
    TRUNC      = 2'd0,
    HALF_UP    = 2'd1,
    CONVERGENT = 2'd2
  } round_mode_e;

  // Register stages from the din sampling edge to the dout register.
  localparam int LATENCY = 5;

endpackage

// File: rtl/mult_round_lane.sv
// One multiplier lane: signed fixed-point multiply, then round and saturate.
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset
//   i_valid  - input qualifier; when low the input registers load zero
//   i_din1   - signed multiplicand, DIN1_POINT fractional bits
//   i_din2   - signed multiplier,   DIN2_POINT fractional bits
//   o_dout   - rounded, saturated product, DOUT_POINT fractional bits
//   o_ovf    - high when o_dout was clamped
// Pipeline: two input registers, product, product re-register, round/saturate.
module mult_round_lane
  import mult_pkg::*;
#(
  parameter int DIN1_WIDTH = 16,
  parameter int DIN1_POINT = 14,
  parameter int DIN2_WIDTH = 16,
  parameter int DIN2_POINT = 14,
  parameter int DOUT_WIDTH = 16,
  parameter int DOUT_POINT = 14,
  parameter int ROUND_MODE = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_valid,
  input  logic signed [DIN1_WIDTH-1:0] i_din1,
  input  logic signed [DIN2_WIDTH-1:0] i_din2,
  output logic signed [DOUT_WIDTH-1:0] o_dout,
  output logic                         o_ovf
);

  localparam int PW    = DIN1_WIDTH + DIN2_WIDTH;
  localparam int SHIFT = DIN1_POINT + DIN2_POINT - DOUT_POINT;
  // Wide enough to hold the shifted product and both clamp limits.
  localparam int EW    = ((PW + 1 > DOUT_WIDTH) ? PW + 1 : DOUT_WIDTH) + 1;

  localparam logic signed [EW-1:0] SAT_MAX =
    {{(EW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN =
    {{(EW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

  logic signed [DIN1_WIDTH-1:0] r_a1, r_a2;
  logic signed [DIN2_WIDTH-1:0] r_b1, r_b2;
  logic signed [PW-1:0]         r_prod, r_prod2;
  logic signed [PW:0]           w_shifted;
  logic signed [EW-1:0]         w_q;
  logic signed [DOUT_WIDTH-1:0] w_sat;
  logic                         w_ovf;

  generate
    if (SHIFT < 0 || SHIFT >= PW) begin : g_bad_shift
      $error("mult_round_lane: output binary point gives an illegal shift");
    end
    if (ROUND_MODE < int'(TRUNC) || ROUND_MODE > int'(CONVERGENT)) begin : g_bad_mode
      $error("mult_round_lane: unknown ROUND_MODE");
    end

    if (SHIFT == 0) begin : g_no_round
      assign w_shifted = {r_prod2[PW-1], r_prod2};
    end else begin : g_round
      localparam logic signed [PW:0] ONE  = 1;
      localparam logic signed [PW:0] HALF = ONE <<< (SHIFT - 1);
      logic signed [PW:0] w_bias;
      logic signed [PW:0] w_sum;

      // Rounding is a bias added before the arithmetic shift. Convergent uses
      // half-1 plus the kept LSB, so an exact tie carries only on an odd LSB.
      always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        w_bias = '0;
        if (ROUND_MODE == int'(HALF_UP)) begin
          w_bias = HALF;
        end else if (ROUND_MODE == int'(CONVERGENT)) begin
          w_bias = HALF - ONE + {{PW{1'b0}}, r_prod2[SHIFT]};
        end
      end

      // One extra MSB keeps a rounding carry from wrapping the sign.
      assign w_sum     = {r_prod2[PW-1], r_prod2} + w_bias;
      assign w_shifted = w_sum >>> SHIFT;
    end
  endgenerate

  assign w_q = {{(EW-PW-1){w_shifted[PW]}}, w_shifted};

  // Saturation sees the post-rounding value, so a rounding carry past the
  // positive limit clamps and flags just like a large product.
  always_comb begin
    w_sat = w_q[DOUT_WIDTH-1:0];
    w_ovf = 1'b0;
    if (w_q > SAT_MAX) begin
      w_sat = SAT_MAX[DOUT_WIDTH-1:0];
      w_ovf = 1'b1;
    end else if (w_q < SAT_MIN) begin
      w_sat = SAT_MIN[DOUT_WIDTH-1:0];
      w_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a1    <= '0;
      r_b1    <= '0;
      r_a2    <= '0;
      r_b2    <= '0;
      r_prod  <= '0;
      r_prod2 <= '0;
      o_dout  <= '0;
      o_ovf   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the value its
      // predecessor held before this edge.
      // Idle cycles load zero, which flows out as dout=0 and ovf=0.
      r_a1    <= i_valid ? i_din1 : '0;
      r_b1    <= i_valid ? i_din2 : '0;
      r_a2    <= r_a1;
      r_b2    <= r_b1;
      r_prod  <= r_a2 * r_b2;
      r_prod2 <= r_prod;
      o_dout  <= w_sat;
      o_ovf   <= w_ovf;
    end
  end

endmodule

// File: rtl/parallel_mult_sat.sv
// PARALLEL independent fixed-point multiplier lanes with rounding/saturation.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   din1/din2  - packed lane inputs, lane i at [W*i +: W]
//   din_valid  - common input qualifier
//   ovf_clear  - clears ovf_sticky (a same-cycle overflow still sets it)
//   dout       - packed rounded, saturated products
//   dout_valid - qualifies dout and ovf, 5 cycles after din_valid
//   ovf        - per-lane clamp flag aligned with dout
//   ovf_sticky - per-lane clamp history
module parallel_mult_sat
  import mult_pkg::*;
#(
  parameter int PARALLEL   = 4,
  parameter int DIN1_WIDTH = 16,
  parameter int DIN1_POINT = 14,
  parameter int DIN2_WIDTH = 16,
  parameter int DIN2_POINT = 14,
  parameter int DOUT_WIDTH = 16,
  parameter int DOUT_POINT = 14,
  parameter int ROUND_MODE = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DIN1_WIDTH*PARALLEL-1:0] din1,
  input  logic [DIN2_WIDTH*PARALLEL-1:0] din2,
  input  logic                           din_valid,
  input  logic                           ovf_clear,
  output logic [DOUT_WIDTH*PARALLEL-1:0] dout,
  output logic                           dout_valid,
  output logic [PARALLEL-1:0]            ovf,
  output logic [PARALLEL-1:0]            ovf_sticky
);

  logic [LATENCY-1:0]  r_vld;
  logic [PARALLEL-1:0] r_sticky;
  logic [PARALLEL-1:0] w_ovf;

  generate
    for (genvar i = 0; i < PARALLEL; i++) begin : g_lane
      mult_round_lane #(
        .DIN1_WIDTH (DIN1_WIDTH),
        .DIN1_POINT (DIN1_POINT),
        .DIN2_WIDTH (DIN2_WIDTH),
        .DIN2_POINT (DIN2_POINT),
        .DOUT_WIDTH (DOUT_WIDTH),
        .DOUT_POINT (DOUT_POINT),
        .ROUND_MODE (ROUND_MODE)
      ) u_lane (
        .clk     (clk),
        .rst     (rst),
        .i_valid (din_valid),
        .i_din1  (din1[DIN1_WIDTH*i +: DIN1_WIDTH]),
        .i_din2  (din2[DIN2_WIDTH*i +: DIN2_WIDTH]),
        .o_dout  (dout[DOUT_WIDTH*i +: DOUT_WIDTH]),
        .o_ovf   (w_ovf[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld    <= '0;
      r_sticky <= '0;
    end else begin
      r_vld    <= {r_vld[LATENCY-2:0], din_valid};
      // Clear is applied first and new overflows OR-ed after, so set wins.
      r_sticky <= (r_sticky & ~{PARALLEL{ovf_clear}}) | (w_ovf & {PARALLEL{dout_valid}});
    end
  end

  assign dout_valid = r_vld[LATENCY-1];
  assign ovf        = w_ovf;
  assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_parallel_mult_sat.sv
// Self-checking bench for parallel_mult_sat. Four instances share clk, rst,
// din_valid and ovf_clear: the default 4-lane convergent build, single-lane
// truncate and half-up builds fed from lane 0, and an 18x25->32 wide build.
module tb_parallel_mult_sat;

  logic        clk = 1'b0;
  logic        rst, din_valid, ovf_clear;
  logic [63:0] din1, din2;
  logic [17:0] wdin1;
  logic [24:0] wdin2;

  logic [63:0] c_dout;  logic c_dv;  logic [3:0] c_ovf;  logic [3:0] c_sticky;
  logic [15:0] t_dout;  logic t_dv;  logic [0:0] t_ovf;  logic [0:0] t_sticky;
  logic [15:0] h_dout;  logic h_dv;  logic [0:0] h_ovf;  logic [0:0] h_sticky;
  logic [31:0] w_dout;  logic w_dv;  logic [0:0] w_ovf;  logic [0:0] w_sticky;

  always #5 clk = ~clk;

  parallel_mult_sat #(.PARALLEL(4), .ROUND_MODE(2)) dut_c (
    .clk(clk), .rst(rst), .din1(din1), .din2(din2), .din_valid(din_valid),
    .ovf_clear(ovf_clear), .dout(c_dout), .dout_valid(c_dv), .ovf(c_ovf),
    .ovf_sticky(c_sticky));

  parallel_mult_sat #(.PARALLEL(1), .ROUND_MODE(0)) dut_t (
    .clk(clk), .rst(rst), .din1(din1[15:0]), .din2(din2[15:0]), .din_valid(din_valid),
    .ovf_clear(ovf_clear), .dout(t_dout), .dout_valid(t_dv), .ovf(t_ovf),
    .ovf_sticky(t_sticky));

  parallel_mult_sat #(.PARALLEL(1), .ROUND_MODE(1)) dut_h (
    .clk(clk), .rst(rst), .din1(din1[15:0]), .din2(din2[15:0]), .din_valid(din_valid),
    .ovf_clear(ovf_clear), .dout(h_dout), .dout_valid(h_dv), .ovf(h_ovf),
    .ovf_sticky(h_sticky));

  parallel_mult_sat #(.PARALLEL(1), .DIN1_WIDTH(18), .DIN1_POINT(17), .DIN2_WIDTH(25),
                      .DIN2_POINT(24), .DOUT_WIDTH(32), .DOUT_POINT(30), .ROUND_MODE(2)) dut_w (
    .clk(clk), .rst(rst), .din1(wdin1), .din2(wdin2), .din_valid(din_valid),
    .ovf_clear(ovf_clear), .dout(w_dout), .dout_valid(w_dv), .ovf(w_ovf),
    .ovf_sticky(w_sticky));

  typedef struct {
    bit          valid;
    logic [63:0] d1, d2;
    logic [17:0] w1;
    logic [24:0] w2;
  } rec_t;

  rec_t   pipe[$];
  int     n_chk = 0;
  int     n_bad = 0;
  int     dv_count;

  // Reference expectations for the outputs currently visible.
  bit     exp_dv;
  longint exp_c[4];  bit exp_c_ovf[4];  bit st_c[4];
  longint exp_t;     bit exp_t_ovf;     bit st_t;
  longint exp_h;     bit exp_h_ovf;     bit st_h;
  longint exp_w;     bit exp_w_ovf;     bit st_w;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Exact product p has s fractional bits too many: divide by 2^s with the
  // selected rounding rule, then clamp to a dw-bit signed range.
  function automatic longint ref_round(input longint p, input int s, input int mode,
                                       input int dw, output bit o);
    longint q, r, half, hi, lo;
    q = p;
    if (s > 0) begin
      q    = p >>> s;              // floor(p / 2^s)
      r    = p - (q <<< s);        // remainder in [0, 2^s)
      half = longint'(1) <<< (s - 1);
      if (mode == 1 && r >= half) q = q + 1;
      if (mode == 2 && (r > half || (r == half && (q & 1) != 0))) q = q + 1;
    end
    hi = (longint'(1) <<< (dw - 1)) - 1;
    lo = -hi - 1;
    o  = 1'b0;
    if (q > hi) begin q = hi; o = 1'b1; end
    if (q < lo) begin q = lo; o = 1'b1; end
    return q;
  endfunction

  function automatic longint lane16(input logic [63:0] v, input int i);
    logic [15:0] w;
    w = v[16*i +: 16];
    return longint'($signed(w));
  endfunction

  task automatic set_expect(input rec_t r);
    longint p;
    exp_dv = r.valid;
    for (int i = 0; i < 4; i++) begin
      exp_c[i] = 0; exp_c_ovf[i] = 1'b0;
    end
    exp_t = 0; exp_t_ovf = 1'b0; exp_h = 0; exp_h_ovf = 1'b0;
    exp_w = 0; exp_w_ovf = 1'b0;
    if (r.valid) begin
      for (int i = 0; i < 4; i++) begin
        p = lane16(r.d1, i) * lane16(r.d2, i);
        exp_c[i] = ref_round(p, 14, 2, 16, exp_c_ovf[i]);
      end
      p = lane16(r.d1, 0) * lane16(r.d2, 0);
      exp_t = ref_round(p, 14, 0, 16, exp_t_ovf);
      exp_h = ref_round(p, 14, 1, 16, exp_h_ovf);
      p = longint'($signed(r.w1)) * longint'($signed(r.w2));
      exp_w = ref_round(p, 11, 2, 32, exp_w_ovf);
    end
  endtask

  // Advance one clock with the inputs currently driven, update the model and
  // compare every output 1 time unit after the edge.
  task automatic cycle();
    rec_t r, idle;
    for (int i = 0; i < 4; i++)
      st_c[i] = !rst && ((st_c[i] && !ovf_clear) || (exp_dv && exp_c_ovf[i]));
    st_t = !rst && ((st_t && !ovf_clear) || (exp_dv && exp_t_ovf));
    st_h = !rst && ((st_h && !ovf_clear) || (exp_dv && exp_h_ovf));
    st_w = !rst && ((st_w && !ovf_clear) || (exp_dv && exp_w_ovf));
    r.valid = din_valid; r.d1 = din1; r.d2 = din2; r.w1 = wdin1; r.w2 = wdin2;
    idle.valid = 1'b0; idle.d1 = '0; idle.d2 = '0; idle.w1 = '0; idle.w2 = '0;
    @(posedge clk);
    if (rst) begin
      foreach (pipe[k]) pipe[k].valid = 1'b0;
      r.valid = 1'b0;
    end
    pipe.push_back(r);
    if (pipe.size() > 5) void'(pipe.pop_front());
    if (pipe.size() == 5) set_expect(pipe[0]);
    else                  set_expect(idle);
    #1;
    check("c_dv", 64'(c_dv), 64'(exp_dv));
    check("t_dv", 64'(t_dv), 64'(exp_dv));
    check("h_dv", 64'(h_dv), 64'(exp_dv));
    check("w_dv", 64'(w_dv), 64'(exp_dv));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("c_dout%0d", i), 64'(lane16(c_dout, i)), 64'(exp_c[i]));
      check($sformatf("c_ovf%0d", i), 64'(c_ovf[i]), 64'(exp_c_ovf[i]));
      check($sformatf("c_sticky%0d", i), 64'(c_sticky[i]), 64'(st_c[i]));
    end
    check("t_dout", 64'(lane16({48'd0, t_dout}, 0)), 64'(exp_t));
    check("t_ovf", 64'(t_ovf), 64'(exp_t_ovf));
    check("t_sticky", 64'(t_sticky), 64'(st_t));
    check("h_dout", 64'(lane16({48'd0, h_dout}, 0)), 64'(exp_h));
    check("h_ovf", 64'(h_ovf), 64'(exp_h_ovf));
    check("h_sticky", 64'(h_sticky), 64'(st_h));
    check("w_dout", 64'(longint'($signed(w_dout))), 64'(exp_w));
    check("w_ovf", 64'(w_ovf), 64'(exp_w_ovf));
    check("w_sticky", 64'(w_sticky), 64'(st_w));
    if (c_dv) dv_count++;
  endtask

  task automatic idle_cycles(input int n);
    din_valid = 1'b0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  function automatic logic [63:0] pack4(input logic [15:0] l3, input logic [15:0] l2,
                                        input logic [15:0] l1, input logic [15:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  initial begin
    exp_dv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_c[i] = 0; exp_c_ovf[i] = 1'b0; st_c[i] = 1'b0;
    end
    exp_t = 0; exp_t_ovf = 0; st_t = 0; exp_h = 0; exp_h_ovf = 0; st_h = 0;
    exp_w = 0; exp_w_ovf = 0; st_w = 0;
    rst = 1'b1; din_valid = 1'b0; ovf_clear = 1'b0;
    din1 = '0; din2 = '0; wdin1 = '0; wdin2 = '0;

    // Reset state.
    @(negedge clk);
    idle_cycles(3);
    check("rst_dout", c_dout, 64'd0);
    check("rst_sticky", 64'(c_sticky), 64'd0);
    rst = 1'b0;
    idle_cycles(2);

    // 0.5 x 0.5 on every lane, single valid cycle.
    din1 = pack4(16'h2000, 16'h2000, 16'h2000, 16'h2000);
    din2 = din1;
    din_valid = 1'b1;
    cycle();
    idle_cycles(4);
    check("half_sq_dv", 64'(c_dv), 64'd1);
    check("half_sq_dout0", 64'(c_dout[15:0]), 64'h1000);
    check("half_sq_ovf", 64'(c_ovf), 64'd0);
    idle_cycles(1);
    check("half_sq_dv_one", 64'(c_dv), 64'd0);

    // Rounding ties, rounding carry into saturation and -2 x -2.
    din_valid = 1'b1;
    din1 = pack4(16'h8000, 16'h6060, 16'h0003, 16'h0001);
    din2 = pack4(16'h8000, 16'h5500, 16'h2000, 16'h2000);
    cycle();
    din1[15:0] = 16'h0003;
    cycle();
    din1[15:0] = 16'h6060;
    din2[15:0] = 16'h5500;
    cycle();
    idle_cycles(2);
    check("tie_conv_0p5", 64'(c_dout[15:0]), 64'h0000);
    check("tie_conv_1p5", 64'(c_dout[31:16]), 64'h0002);
    check("carry_sat_dout", 64'(c_dout[47:32]), 64'h7FFF);
    check("carry_sat_ovf", 64'(c_ovf[2]), 64'd1);
    check("neg2sq_dout", 64'(c_dout[63:48]), 64'h7FFF);
    check("neg2sq_ovf", 64'(c_ovf[3]), 64'd1);
    check("trunc_0p5", 64'(t_dout), 64'h0000);
    check("halfup_0p5", 64'(h_dout), 64'h0001);
    idle_cycles(1);
    check("trunc_1p5", 64'(t_dout), 64'h0001);
    check("halfup_1p5", 64'(h_dout), 64'h0002);
    check("sticky_set", 64'(c_sticky), 64'hC);
    idle_cycles(1);
    check("trunc_carry_dout", 64'(t_dout), 64'h7FFF);
    check("trunc_carry_ovf", 64'(t_ovf), 64'd0);
    check("halfup_carry_ovf", 64'(h_ovf), 64'd1);
    // Clear in the same cycle the overflow is recorded: set wins.
    ovf_clear = 1'b1;
    idle_cycles(1);
    check("set_wins_h", 64'(h_sticky), 64'd1);
    idle_cycles(1);
    ovf_clear = 1'b0;
    check("sticky_cleared", 64'(c_sticky), 64'd0);
    idle_cycles(1);

    // 100 back-to-back random samples.
    dv_count = 0;
    din_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      din1  = {$urandom, $urandom};
      din2  = {$urandom, $urandom};
      wdin1 = 18'($urandom);
      wdin2 = 25'($urandom);
      if (n % 13 == 5) begin
        wdin1 = 18'h20000;
        wdin2 = 25'h1000000;
      end
      ovf_clear = ($urandom_range(0, 9) == 0);
      cycle();
    end
    ovf_clear = 1'b0;
    idle_cycles(6);
    check("burst_dv_count", 64'(dv_count), 64'd100);

    // Reset two cycles after a 3-sample overflowing burst drops the burst.
    din_valid = 1'b1;
    din1 = pack4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    din2 = din1;
    for (int n = 0; n < 3; n++) cycle();
    idle_cycles(1);
    dv_count = 0;
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    idle_cycles(8);
    check("rst_burst_dv", 64'(dv_count), 64'd0);
    check("rst_burst_sticky", 64'(c_sticky), 64'd0);
    check("rst_burst_dout", c_dout, 64'd0);

    // First sample after reset release still has full latency.
    din_valid = 1'b1;
    din1 = pack4(16'h1000, 16'hC000, 16'h4000, 16'h7FFF);
    din2 = pack4(16'hF000, 16'h4000, 16'hC000, 16'h7FFF);
    wdin1 = 18'h1FFFF;
    wdin2 = 25'h0FFFFFF;
    cycle();
    idle_cycles(6);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
